// File: rtl/serial_word_deserializer_pkg.sv
// Shared definitions for the serial word deserializer: FSM state encoding
// and a constant-evaluable ceiling log2 used to size the bit counter.
package serial_word_deserializer_pkg;

    typedef enum logic {
        ST_SHIFT = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Number of bits needed to count 0 .. value-1 (at least 1 for value >= 2).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_word_deserializer_shift_reg.sv
// MSB-first shift register: each enabled shift moves the word left and
// appends the new serial bit at bit 0. Synchronous clear has priority.
module sw_deser_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Shift storage: clear wins, otherwise shift in din when enabled.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= {WIDTH{1'b0}};
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], din};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word deserializer (MSB first) with valid/ready on both
// sides. One shift stage plus one output holding register; when the holding
// register is busy at frame end the FSM parks in FULL with the finished word
// still in the shift register until the consumer frees the holding register.
// Optional feature macro: PARITY_CHECK_EN (adds a trailing even-parity bit
// per frame and drives parity_err for the word in dout).
module serial_word_deserializer
    import serial_word_deserializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             proto_err,
    output logic             parity_err
);

`ifdef PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int            CW   = clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    // Even-parity check: 1 when the data bits plus parity bit have odd weight.
    function automatic logic parity_mismatch(input logic [WIDTH-1:0] data,
                                             input logic             pbit);
        return (^data) ^ pbit;
    endfunction

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic             pend_perr_r;
    logic [WIDTH-1:0] shreg_s;

    logic             accept_s;
    logic             last_s;
    logic             hold_free_s;
    logic             consume_s;
    logic             shift_en_s;
    logic [WIDTH-1:0] frame_word_s;
    logic             frame_perr_s;
    logic             load_s;
    logic [WIDTH-1:0] load_word_s;
    logic             load_perr_s;

    // din_ready is a pure decode of the registered state.
    assign din_ready = (state_r == ST_SHIFT);

    sw_deser_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift_reg (
        .clk     (clk),
        .clr     (rst),
        .shift_en(shift_en_s),
        .din     (din),
        .q       (shreg_s)
    );

    // Handshake decode, frame-end word/parity selection and holding-register load.
    always_comb begin
        accept_s    = din_valid & din_ready;
        last_s      = accept_s & (cnt_r == LAST);
        hold_free_s = ~dout_valid | dout_ready;
        consume_s   = dout_valid & dout_ready;
`ifdef PARITY_CHECK_EN
        // The trailing parity bit is checked but never enters the word.
        shift_en_s   = accept_s & (cnt_r != LAST);
        frame_word_s = shreg_s;
        frame_perr_s = parity_mismatch(shreg_s, din);
`else
        // The last bit completes the word on the same edge it is accepted.
        shift_en_s   = accept_s;
        frame_word_s = {shreg_s[WIDTH-2:0], din};
        frame_perr_s = 1'b0;
`endif
        load_s      = 1'b0;
        load_word_s = frame_word_s;
        load_perr_s = frame_perr_s;
        case (state_r)
            ST_SHIFT: begin
                if (last_s && hold_free_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_FULL: begin
                // Parked word sits complete in the shift register.
                if (hold_free_s) begin
                    load_s      = 1'b1;
                    load_word_s = shreg_s;
                    load_perr_s = pend_perr_r;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // FSM, bit counter, holding register and sticky protocol flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_SHIFT;
            cnt_r       <= {CW{1'b0}};
            pend_perr_r <= 1'b0;
            dout        <= {WIDTH{1'b0}};
            dout_valid  <= 1'b0;
            parity_err  <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            if (din_valid && !din_ready) begin
                proto_err <= 1'b1;
            end

            // A load on the same edge as a consume keeps dout_valid high.
            if (load_s) begin
                dout       <= load_word_s;
                parity_err <= load_perr_s;
                dout_valid <= 1'b1;
            end else if (consume_s) begin
                dout_valid <= 1'b0;
            end

            if (accept_s) begin
                cnt_r <= (cnt_r == LAST) ? {CW{1'b0}} : cnt_r + CW'(1);
            end

            case (state_r)
                ST_SHIFT: begin
                    if (last_s && !hold_free_s) begin
                        state_r     <= ST_FULL;
                        pend_perr_r <= frame_perr_s;
                    end
                end
                ST_FULL: begin
                    if (hold_free_s) begin
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    state_r <= ST_SHIFT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench for serial_word_deserializer (WIDTH=8). Table-driven
// words plus hand-written back-pressure / protocol / reset sequences; every
// consumed word is checked against a scoreboard queue filled at stimulus time.
module tb_serial_word_deserializer;

    localparam int W = 8;
`ifdef PARITY_CHECK_EN
    localparam int FRAME = W + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = W;
    localparam bit PAR   = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         din;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         proto_err;
    logic         parity_err;

    serial_word_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .proto_err (proto_err),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        logic       pbit;
        logic       perr;   // expected parity_err when the parity feature is built in
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] sb_q[$];
    vec_t       vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; a word consumed on this edge is checked against the scoreboard.
    task automatic tick();
        logic       v, r, p, rs;
        logic [7:0] d;
        logic [8:0] e;
        v  = dout_valid;
        r  = dout_ready;
        d  = dout;
        p  = parity_err;
        rs = rst;
        @(posedge clk);
        #1;
        if (v && r && !rs) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_extra_word: got %0h expected no word", d);
            end else begin
                e = sb_q.pop_front();
                check("sb_word", {23'd0, p, d}, {23'd0, e});
            end
        end
    endtask

    task automatic send_word(input logic [7:0] w, input logic pb, input logic perr,
                             input bit gap, input bit chk_lat);
        for (int i = 0; i < FRAME; i++) begin
            din_valid = 1'b1;
            din       = (i < 8) ? w[3'(7 - i)] : pb;
            if (i == FRAME - 1) begin
                sb_q.push_back({PAR ? perr : 1'b0, w});
                if (chk_lat) check("pre_last_valid", 32'(dout_valid), 32'd0);
            end
            tick();
            if (gap) begin
                din_valid = 1'b0;
                din       = ~din;
                tick();
            end
        end
        din_valid = 1'b0;
        if (chk_lat) begin
            check("lat_valid", 32'(dout_valid), 32'd1);
            check("lat_dout",  32'(dout), 32'(w));
            check("lat_perr",  32'(parity_err), PAR ? 32'(perr) : 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1};
        vecs[2] = '{8'h3C, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 1'b1, 1'b0};
        vecs[4] = '{8'h07, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 1'b1, 1'b1};

        rst = 1'b1; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;

        // 1: reset state
        tick();
        tick();
        check("rst_dout",       32'(dout), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_proto_err",  32'(proto_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_din_ready",  32'(din_ready), 32'd1);
        rst = 1'b0;

        // 2 / 6: table of words, consumer always ready
        dout_ready = 1'b1;
        foreach (vecs[k]) begin
            send_word(vecs[k].word, vecs[k].pbit, vecs[k].perr, 1'b0, 1'b1);
        end
        tick();
        check("tbl_drained",   32'(dout_valid), 32'd0);
        check("tbl_proto_err", 32'(proto_err), 32'd0);

        // 3: two words under back-pressure, then a single-cycle consume
        dout_ready = 1'b0;
        send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_din_ready", 32'(din_ready), 32'd0);
        check("bp_dout",      32'(dout), 32'h3C);
        check("bp_valid",     32'(dout_valid), 32'd1);
        repeat (3) tick();
        check("bp_hold_dout", 32'(dout), 32'h3C);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("bp_next_dout",  32'(dout), 32'hC3);
        check("bp_next_valid", 32'(dout_valid), 32'd1);
        check("bp_ready_back", 32'(din_ready), 32'd1);
        dout_ready = 1'b1;
        tick();
        check("bp_drained", 32'(dout_valid), 32'd0);

        // 4: din_valid toggling mid-word
        send_word(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (FRAME + 2) tick();
        check("gap_sb_empty", 32'(sb_q.size()), 32'd0);
        check("gap_valid",    32'(dout_valid), 32'd0);

        // 5: protocol error in FULL, reset in FULL, reset mid-word
        dout_ready = 1'b0;
        send_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        din_valid = 1'b1;
        din       = 1'b1;
        tick();
        din_valid = 1'b0;
        check("pe_set",       32'(proto_err), 32'd1);
        check("pe_full",      32'(din_ready), 32'd0);
        repeat (2) tick();
        check("pe_sticky",    32'(proto_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        check("rstf_valid",   32'(dout_valid), 32'd0);
        check("rstf_ready",   32'(din_ready), 32'd1);
        check("rstf_pe",      32'(proto_err), 32'd0);
        check("rstf_dout",    32'(dout), 32'd0);
        dout_ready = 1'b1;
        din_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = (i < 2) ? 1'b1 : 1'b0;
            tick();
        end
        din_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (FRAME + 2) tick();
        check("rstm_valid", 32'(dout_valid), 32'd0);
        send_word(8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("end_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
